regs_loader: RTL and testbench

- Host-to-core counterpart of the register-snapshot export path.
- Accepts a packed architectural snapshot from the simulation host (checkpoint restore / difftest resync) and replays it into the core.
- Drives the GPR file write port one register per cycle, then the PC, while holding the core stalled.
- Sits beside the register file and PC register. Uses the same 33x32-bit snapshot layout as the export side.

---
 rtl/regs_pkg.sv | 24 ++
 rtl/regs_loader.sv | 109 ++++++++++
 tb/tb_regs_loader.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/regs_pkg.sv
// Snapshot layout shared by the register export and load paths.
// 33 slots of 32 bits: x0..x31 in slots 0..31, next PC in slot 32.
package regs_pkg;

  localparam int SNAP_W  = 33 * 32;
  localparam int NPC_LSB = 1024;

  typedef enum logic [1:0] {IDLE, GPR, PC, DONE} loader_state_e;

  function automatic logic [31:0] snap_slot(input logic [SNAP_W-1:0] snap, input int unsigned i);
    return snap[32*i +: 32];
  endfunction

  // A snapshot is malformed if x0 is nonzero or any unimplemented GPR slot is nonzero.
  function automatic logic snap_malformed(input logic [SNAP_W-1:0] snap, input int unsigned nr_regs);
    logic bad;
    bad = (snap_slot(snap, 0) != 32'h0);
    for (int unsigned i = 1; i < 32; i++) begin
      if (i >= nr_regs && snap_slot(snap, i) != 32'h0) bad = 1'b1;
    end
    return bad;
  endfunction

endpackage

// File: rtl/regs_loader.sv
// Replays a host snapshot into the core: x1..x(NR_REGS-1) one per cycle, then the PC, then a done pulse.
// All outputs are registered; req_ready_o is high only in IDLE and requests while busy are ignored.
module regs_loader
  import regs_pkg::*;
#(
  parameter int NR_REGS = 16
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       req_valid_i,
  output logic                       req_ready_o,
  input  logic [SNAP_W-1:0]          snap_i,
  output logic                       rf_we_o,
  output logic [$clog2(NR_REGS)-1:0] rf_waddr_o,
  output logic [31:0]                rf_wdata_o,
  output logic                       pc_we_o,
  output logic [31:0]                pc_wdata_o,
  output logic                       core_stall_o,
  output logic                       done_o,
  output logic                       err_o
);

  localparam int AW = $clog2(NR_REGS);
  localparam logic [AW-1:0] LAST_IDX = AW'(NR_REGS - 1);

  loader_state_e     state_q;
  logic [AW-1:0]     idx_q;
  logic [AW-1:0]     idx_d;
  logic [SNAP_W-1:0] snap_q;
  logic              rf_we_q;
  logic [AW-1:0]     rf_waddr_q;
  logic [31:0]       rf_wdata_q;
  logic              pc_we_q;
  logic [31:0]       pc_wdata_q;
  logic              stall_q;
  logic              done_q;
  logic              err_q;

  assign idx_d = idx_q + AW'(1);

  // The first write is staged straight from snap_i at acceptance so x1 lands in the very next cycle.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      snap_q     <= '0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      pc_we_q    <= 1'b0;
      pc_wdata_q <= '0;
      stall_q    <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid_i) begin
            state_q    <= GPR;
            snap_q     <= snap_i;
            idx_q      <= AW'(1);
            err_q      <= snap_malformed(snap_i, NR_REGS);
            rf_we_q    <= 1'b1;
            rf_waddr_q <= AW'(1);
            rf_wdata_q <= snap_slot(snap_i, 1);
            stall_q    <= 1'b1;
          end
        end
        GPR: begin
          if (idx_q == LAST_IDX) begin
            state_q    <= PC;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
            pc_we_q    <= 1'b1;
            pc_wdata_q <= snap_q[NPC_LSB +: 32];
          end else begin
            idx_q      <= idx_d;
            rf_waddr_q <= idx_d;
            rf_wdata_q <= snap_slot(snap_q, idx_d);
          end
        end
        PC: begin
          state_q    <= DONE;
          pc_we_q    <= 1'b0;
          pc_wdata_q <= '0;
          done_q     <= 1'b1;
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
          stall_q <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready_o  = (state_q == IDLE);
  assign rf_we_o      = rf_we_q;
  assign rf_waddr_o   = rf_waddr_q;
  assign rf_wdata_o   = rf_wdata_q;
  assign pc_we_o      = pc_we_q;
  assign pc_wdata_o   = pc_wdata_q;
  assign core_stall_o = stall_q;
  assign done_o       = done_q;
  assign err_o        = err_q;

endmodule

// File: tb/tb_regs_loader.sv
// Scoreboard bench for regs_loader at NR_REGS=16 and 32, with a transaction-level reference model.
module tb_regs_loader;
  import regs_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  bit inst_done [2];

  typedef struct {
    int          kind;   // 0 = GPR write, 1 = PC write, 2 = done pulse
    int          addr;
    logic [31:0] data;
    int          cyc;
  } ev_t;

  task automatic chk(input string name, input int inst, input int cyc,
                     input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s inst=%0d cyc=%0d actual=%0h required=%0h", name, inst, cyc, act, exp);
    end
  endtask

  function automatic logic [SNAP_W-1:0] rand_snap();
    logic [SNAP_W-1:0] s;
    for (int i = 0; i < 33; i++) s[32*i +: 32] = $urandom;
    return s;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : u
    localparam int NR = (g == 0) ? 16 : 32;
    localparam int AW = $clog2(NR);

    logic              resetn, req_valid, req_ready;
    logic [SNAP_W-1:0] snap;
    logic              rf_we, pc_we, core_stall, done, err;
    logic [AW-1:0]     rf_waddr;
    logic [31:0]       rf_wdata, pc_wdata;

    regs_loader #(.NR_REGS(NR)) dut (
      .clk          (clk),
      .resetn       (resetn),
      .req_valid_i  (req_valid),
      .req_ready_o  (req_ready),
      .snap_i       (snap),
      .rf_we_o      (rf_we),
      .rf_waddr_o   (rf_waddr),
      .rf_wdata_o   (rf_wdata),
      .pc_we_o      (pc_we),
      .pc_wdata_o   (pc_wdata),
      .core_stall_o (core_stall),
      .done_o       (done),
      .err_o        (err)
    );

    ev_t q[$];
    int  cyc       = 0;
    int  busy_left = 0;
    int  acc_cnt   = 0;
    bit  err_exp   = 1'b0;
    bit  mon_en    = 1'b0;

    // Reference model: a load occupies NR+1 cycles after acceptance and emits a fixed event list.
    always @(posedge clk) begin
      cyc++;
      if (!resetn) begin
        q.delete();
        busy_left = 0;
        err_exp   = 1'b0;
      end else if (busy_left > 0) begin
        busy_left--;
      end else if (req_valid) begin
        for (int i = 1; i < NR; i++) q.push_back('{0, i, snap[32*i +: 32], cyc + i - 1});
        q.push_back('{1, 0, snap[1024 +: 32], cyc + NR - 1});
        q.push_back('{2, 0, 32'h0, cyc + NR});
        err_exp = (snap[31:0] != 32'h0);
        for (int i = NR; i < 32; i++) if (snap[32*i +: 32] != 32'h0) err_exp = 1'b1;
        busy_left = NR + 1;
        acc_cnt++;
      end
    end

    always @(negedge clk) begin
      ev_t e;
      int  k;
      if (mon_en) begin
        chk("req_ready", g, cyc, req_ready, busy_left == 0);
        chk("core_stall", g, cyc, core_stall, busy_left > 0);
        chk("err", g, cyc, err, err_exp);
        if (!rf_we) begin
          chk("rf_waddr_idle", g, cyc, rf_waddr, 0);
          chk("rf_wdata_idle", g, cyc, rf_wdata, 0);
        end
        if (!pc_we) chk("pc_wdata_idle", g, cyc, pc_wdata, 0);
        if (rf_we || pc_we || done) begin
          chk("onehot", g, cyc, 64'(rf_we) + 64'(pc_we) + 64'(done), 1);
          k = rf_we ? 0 : (pc_we ? 1 : 2);
          if (q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_event inst=%0d cyc=%0d actual=kind%0d required=none", g, cyc, k);
          end else begin
            e = q.pop_front();
            chk("ev_kind", g, cyc, k, e.kind);
            chk("ev_cycle", g, cyc, cyc, e.cyc);
            if (e.kind == 0) begin
              chk("rf_waddr", g, cyc, rf_waddr, e.addr);
              chk("rf_wdata", g, cyc, rf_wdata, e.data);
            end else if (e.kind == 1) begin
              chk("pc_wdata", g, cyc, pc_wdata, e.data);
            end
          end
        end
      end
    end

    function automatic logic [SNAP_W-1:0] clean_snap();
      logic [SNAP_W-1:0] s;
      s = rand_snap();
      s[31:0] = 32'h0;
      for (int i = NR; i < 32; i++) s[32*i +: 32] = 32'h0;
      return s;
    endfunction

    task automatic send(input logic [SNAP_W-1:0] s, input bit hold);
      int a0;
      int n;
      a0 = acc_cnt;
      n  = 0;
      req_valid = 1'b1;
      snap      = s;
      while (acc_cnt == a0 && n < 200) begin
        @(posedge clk);
        #1;
        n++;
      end
      if (acc_cnt == a0) begin
        checks++;
        failures++;
        $display("FAIL accept_timeout inst=%0d cyc=%0d actual=not_accepted required=accepted", g, cyc);
      end
      if (!hold) begin
        req_valid = 1'b0;
        snap      = rand_snap();
      end
    endtask

    task automatic wait_idle();
      int n;
      n = 0;
      while (busy_left != 0 && n < 200) begin
        @(posedge clk);
        #1;
        n++;
      end
    endtask

    initial begin
      logic [SNAP_W-1:0] s;
      resetn    = 1'b0;
      req_valid = 1'b0;
      snap      = '0;
      @(posedge clk);
      #1 mon_en = 1'b1;
      repeat (2) @(posedge clk);
      #1 resetn = 1'b1;

      s = '0;
      for (int i = 0; i < 32; i++) begin
        if (g == 0) s[32*i +: 32] = (i < NR) ? 32'h1000_0000 + 32'(i) : 32'h0;
        else        s[32*i +: 32] = ~32'(i);
      end
      if (g == 0) s[31:0] = 32'h0;
      s[1024 +: 32] = 32'h8000_0100;
      send(s, 1'b0);
      wait_idle();

      send(clean_snap(), 1'b1);
      send(clean_snap(), 1'b0);
      wait_idle();

      s = clean_snap();
      s[31:0]       = 32'hDEAD_BEEF;
      s[20*32 +: 32] = 32'h1;
      send(s, 1'b0);
      wait_idle();
      send(clean_snap(), 1'b0);
      wait_idle();

      send(clean_snap(), 1'b0);
      repeat (4) @(posedge clk);
      #1 resetn = 1'b0;
      @(posedge clk);
      #1 resetn = 1'b1;
      repeat (3) @(posedge clk);
      #1;

      repeat (12) begin
        s = ($urandom_range(2) == 0) ? rand_snap() : clean_snap();
        send(s, 1'($urandom_range(1)));
        if (!req_valid && $urandom_range(1) == 1) begin
          wait_idle();
          repeat ($urandom_range(3)) @(posedge clk);
          #1;
        end
      end
      req_valid = 1'b0;
      wait_idle();
      repeat (3) @(posedge clk);
      #1;
      chk("queue_drained", g, cyc, q.size(), 0);
      inst_done[g] = 1'b1;
    end
  end

  initial begin
    int n;
    n = 0;
    while (!(inst_done[0] && inst_done[1]) && n < 20000) begin
      @(posedge clk);
      n++;
    end
    if (n >= 20000) begin
      checks++;
      failures++;
      $display("FAIL global_timeout actual=running required=finished");
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
